// File: rtl/uart_axil_poll_master.sv
// AXI4-Lite initiator for the UART register block: turns a TX byte stream and
// baud-select requests into register writes, polls STATUS and drains RX bytes.
module uart_axil_poll_master #(
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    DATA_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0,
    parameter int                    POLL_DIV   = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    output logic [ADDR_WIDTH-1:0]   m_axil_awaddr,
    output logic                    m_axil_awvalid,
    input  logic                    m_axil_awready,
    output logic [DATA_WIDTH-1:0]   m_axil_wdata,
    output logic [DATA_WIDTH/8-1:0] m_axil_wstrb,
    output logic                    m_axil_wvalid,
    input  logic                    m_axil_wready,
    input  logic [1:0]              m_axil_bresp,
    input  logic                    m_axil_bvalid,
    output logic                    m_axil_bready,
    output logic [ADDR_WIDTH-1:0]   m_axil_araddr,
    output logic                    m_axil_arvalid,
    input  logic                    m_axil_arready,
    input  logic [DATA_WIDTH-1:0]   m_axil_rdata,
    input  logic [1:0]              m_axil_rresp,
    input  logic                    m_axil_rvalid,
    output logic                    m_axil_rready,
    input  logic [7:0]              s_tx_data,
    input  logic                    s_tx_valid,
    output logic                    s_tx_ready,
    output logic [7:0]              m_rx_data,
    output logic                    m_rx_valid,
    input  logic                    m_rx_ready,
    input  logic [2:0]              baud_sel,
    input  logic                    baud_sel_wr,
    output logic                    busy,
    output logic                    err
);
    localparam logic [ADDR_WIDTH-1:0] OFF_TX     = ADDR_WIDTH'(32'h0);
    localparam logic [ADDR_WIDTH-1:0] OFF_RX     = ADDR_WIDTH'(32'h4);
    localparam logic [ADDR_WIDTH-1:0] OFF_STATUS = ADDR_WIDTH'(32'h8);
    localparam logic [ADDR_WIDTH-1:0] OFF_BAUD   = ADDR_WIDTH'(32'hC);
    localparam int                    PW         = (POLL_DIV < 1) ? 1 : $clog2(POLL_DIV + 1);
    localparam logic [PW-1:0]         POLL_LIM   = PW'(POLL_DIV);

    typedef enum logic [2:0] {IDLE, AR_A, R_D, DECIDE, WR_A, WR_B, RX_OUT} state_t;
    state_t state, state_d;

    logic [PW-1:0] poll_cnt;
    logic          baud_pend;
    logic [2:0]    baud_val;
    logic          rd_status;
    logic [7:0]    rdata_q;
    logic [1:0]    rresp_q;
    logic          aw_done, w_done;
    logic          poll_go, rx_go, baud_launch, tx_take;
    logic          aw_hs, w_hs;
    logic          unused_rdata;

    assign unused_rdata   = ^m_axil_rdata[DATA_WIDTH-1:8];
    assign aw_hs          = m_axil_awvalid && m_axil_awready;
    assign w_hs           = m_axil_wvalid && m_axil_wready;
    assign m_axil_awvalid = (state == WR_A) && !aw_done;
    assign m_axil_wvalid  = (state == WR_A) && !w_done;
    assign m_axil_wstrb   = '1;
    assign m_axil_bready  = (state == WR_B);
    assign m_axil_arvalid = (state == AR_A);
    assign m_axil_rready  = (state == R_D);
    assign s_tx_ready     = tx_take;
    assign busy           = (state != IDLE);

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_d;
    end

    always_comb begin
        state_d     = state;
        poll_go     = 1'b0;
        rx_go       = 1'b0;
        baud_launch = 1'b0;
        tx_take     = 1'b0;
        case (state)
            IDLE: begin
                if (baud_pend) begin
                    baud_launch = 1'b1;
                    state_d     = WR_A;
                end else if (poll_cnt == POLL_LIM) begin
                    poll_go = 1'b1;
                    state_d = AR_A;
                end
            end
            AR_A:   if (m_axil_arready) state_d = R_D;
            R_D:    if (m_axil_rvalid) state_d = rd_status ? DECIDE : RX_OUT;
            DECIDE: begin
                // RX drain outranks TX so received bytes are never starved
                if (rresp_q != 2'b00) begin
                    state_d = IDLE;
                end else if (rdata_q[1] && !m_rx_valid) begin
                    rx_go   = 1'b1;
                    state_d = AR_A;
                end else if (!rdata_q[0] && s_tx_valid) begin
                    tx_take = 1'b1;
                    state_d = WR_A;
                end else begin
                    state_d = IDLE;
                end
            end
            WR_A:   if ((aw_done || aw_hs) && (w_done || w_hs)) state_d = WR_B;
            WR_B:   if (m_axil_bvalid) state_d = IDLE;
            RX_OUT: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            poll_cnt      <= '0;
            baud_pend     <= 1'b0;
            baud_val      <= '0;
            rd_status     <= 1'b0;
            rdata_q       <= '0;
            rresp_q       <= '0;
            aw_done       <= 1'b0;
            w_done        <= 1'b0;
            m_axil_awaddr <= '0;
            m_axil_wdata  <= '0;
            m_axil_araddr <= '0;
            m_rx_data     <= '0;
            m_rx_valid    <= 1'b0;
            err           <= 1'b0;
        end else begin
            // a new request in the launch cycle re-arms with the newer code
            if (baud_sel_wr) begin
                baud_pend <= 1'b1;
                baud_val  <= baud_sel;
            end else if (baud_launch) begin
                baud_pend <= 1'b0;
            end
            if (state == IDLE && !baud_pend)
                poll_cnt <= poll_go ? '0 : poll_cnt + 1'b1;
            if (poll_go) begin
                m_axil_araddr <= BASE_ADDR + OFF_STATUS;
                rd_status     <= 1'b1;
            end
            if (rx_go) begin
                m_axil_araddr <= BASE_ADDR + OFF_RX;
                rd_status     <= 1'b0;
            end
            if (state == R_D && m_axil_rvalid) begin
                rdata_q <= m_axil_rdata[7:0];
                rresp_q <= m_axil_rresp;
            end
            if (baud_launch) begin
                m_axil_awaddr <= BASE_ADDR + OFF_BAUD;
                m_axil_wdata  <= DATA_WIDTH'(baud_val);
            end
            if (tx_take) begin
                m_axil_awaddr <= BASE_ADDR + OFF_TX;
                m_axil_wdata  <= DATA_WIDTH'(s_tx_data);
            end
            if (state != WR_A) begin
                aw_done <= 1'b0;
                w_done  <= 1'b0;
            end else begin
                if (aw_hs) aw_done <= 1'b1;
                if (w_hs)  w_done  <= 1'b1;
            end
            if ((state == DECIDE && rresp_q != 2'b00) ||
                (state == RX_OUT && rresp_q != 2'b00) ||
                (state == WR_B && m_axil_bvalid && m_axil_bresp != 2'b00))
                err <= 1'b1;
            if (state == RX_OUT && rresp_q == 2'b00) begin
                m_rx_data  <= rdata_q;
                m_rx_valid <= 1'b1;
            end else if (m_rx_valid && m_rx_ready) begin
                m_rx_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_uart_axil_poll_master.sv
// Self-checking bench: AXI4-Lite slave model plus write/RX scoreboards.
module tb_uart_axil_poll_master;
    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] awaddr, wdata, araddr, rdata;
    logic [3:0]  wstrb;
    logic        awvalid, awready, wvalid, wready, bvalid, bready;
    logic        arvalid, arready, rvalid, rready;
    logic [1:0]  bresp, rresp;
    logic [7:0]  s_tx_data, m_rx_data;
    logic        s_tx_valid, s_tx_ready, m_rx_valid, m_rx_ready;
    logic [2:0]  baud_sel;
    logic        baud_sel_wr, busy, err;

    always #5 clk = ~clk;

    uart_axil_poll_master #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .BASE_ADDR(32'h0), .POLL_DIV(4)) dut (
        .clk(clk), .rst(rst),
        .m_axil_awaddr(awaddr), .m_axil_awvalid(awvalid), .m_axil_awready(awready),
        .m_axil_wdata(wdata), .m_axil_wstrb(wstrb), .m_axil_wvalid(wvalid), .m_axil_wready(wready),
        .m_axil_bresp(bresp), .m_axil_bvalid(bvalid), .m_axil_bready(bready),
        .m_axil_araddr(araddr), .m_axil_arvalid(arvalid), .m_axil_arready(arready),
        .m_axil_rdata(rdata), .m_axil_rresp(rresp), .m_axil_rvalid(rvalid), .m_axil_rready(rready),
        .s_tx_data(s_tx_data), .s_tx_valid(s_tx_valid), .s_tx_ready(s_tx_ready),
        .m_rx_data(m_rx_data), .m_rx_valid(m_rx_valid), .m_rx_ready(m_rx_ready),
        .baud_sel(baud_sel), .baud_sel_wr(baud_sel_wr), .busy(busy), .err(err));

    typedef struct { logic [31:0] addr; logic [31:0] data; } wr_t;
    wr_t        wq[$];
    logic [7:0] rq[$];

    int n_cmp = 0, n_err = 0;
    int n_stat = 0, n_rxrd = 0, n_txacc = 0, n_ovl = 0;
    logic [31:0] status_val = 32'h0;
    logic [7:0]  rx_val = 8'h00;
    logic [1:0]  bresp_cfg = 2'b00;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h @%0t", tag, got, exp, $time);
        end
    endtask

    // slave model; AW before W so the two valids drop on different cycles
    logic        aw_got, w_got;
    logic [31:0] aw_c, w_c;
    logic [3:0]  s_c;
    always @(posedge clk) begin
        if (rst) begin
            awready <= 0; wready <= 0; bvalid <= 0; bresp <= 0;
            arready <= 0; rvalid <= 0; rresp <= 0; rdata <= 0;
            aw_got <= 0; w_got <= 0; aw_c <= 0; w_c <= 0; s_c <= 0;
        end else begin
            arready <= arvalid && !arready && !rvalid;
            if (arvalid && arready) begin
                rvalid <= 1'b1;
                rresp  <= 2'b00;
                rdata  <= (araddr == 32'h8) ? status_val :
                          (araddr == 32'h4) ? {24'h0, rx_val} : 32'hDEAD_BEEF;
                chk("ar_addr_legal", 32'(araddr == 32'h8 || araddr == 32'h4), 32'd1);
                if (araddr == 32'h8) n_stat <= n_stat + 1;
                if (araddr == 32'h4) begin
                    n_rxrd <= n_rxrd + 1;
                    chk("rx_rd_only_when_empty", 32'(m_rx_valid), 32'd0);
                end
            end else if (rvalid && rready) begin
                rvalid <= 1'b0;
            end
            awready <= awvalid && !awready && !aw_got;
            if (awvalid && awready) begin aw_got <= 1'b1; aw_c <= awaddr; end
            wready <= wvalid && !wready && !w_got && aw_got;
            if (wvalid && wready) begin w_got <= 1'b1; w_c <= wdata; s_c <= wstrb; end
            if (aw_got && w_got && !bvalid) begin
                bvalid <= 1'b1;
                bresp  <= bresp_cfg;
                aw_got <= 1'b0;
                w_got  <= 1'b0;
                if (wq.size() == 0) chk("unexpected_write", aw_c, 32'hFFFF_FFFF);
                else begin
                    wr_t e;
                    e = wq.pop_front();
                    chk("wr_addr", aw_c, e.addr);
                    chk("wr_data", w_c, e.data);
                    chk("wr_strb", 32'(s_c), 32'hF);
                end
            end else if (bvalid && bready) begin
                bvalid <= 1'b0;
            end
        end
    end

    always @(posedge clk) begin
        if (!rst) begin
            if (arvalid && (awvalid || wvalid)) n_ovl <= n_ovl + 1;
            if (s_tx_valid && s_tx_ready) n_txacc <= n_txacc + 1;
            if (m_rx_valid && m_rx_ready) begin
                if (rq.size() == 0) chk("unexpected_rx", 32'(m_rx_data), 32'hFFFF_FFFF);
                else chk("rx_data", 32'(m_rx_data), 32'(rq.pop_front()));
            end
        end
    end

    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic wait_wq(input string tag, input int lim);
        for (int i = 0; i < lim && wq.size() != 0; i++) @(negedge clk);
        chk(tag, 32'(wq.size()), 32'd0);
    endtask

    task automatic push_wr(input logic [31:0] a, input logic [31:0] d);
        wr_t e;
        e.addr = a;
        e.data = d;
        wq.push_back(e);
    endtask

    // present a byte and withdraw it right after the handshake
    task automatic tx_send(input logic [7:0] d, input int lim);
        s_tx_data  = d;
        s_tx_valid = 1'b1;
        for (int i = 0; i < lim && !s_tx_ready; i++) @(negedge clk);
        chk("tx_ready_seen", 32'(s_tx_ready), 32'd1);
        @(posedge clk);
        #1 s_tx_valid = 1'b0;
    endtask

    task automatic baud_pulse(input logic [2:0] code);
        baud_sel    = code;
        baud_sel_wr = 1'b1;
        @(negedge clk);
        baud_sel_wr = 1'b0;
    endtask

    initial begin
        int t0, r0;
        rst = 1; s_tx_data = 0; s_tx_valid = 0; m_rx_ready = 0; baud_sel = 0; baud_sel_wr = 0;
        cycles(3);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_err", 32'(err), 0);
        chk("rst_valids", 32'({awvalid, wvalid, arvalid, bready, rready, s_tx_ready, m_rx_valid}), 0);
        chk("rst_addrs", awaddr | araddr | wdata | 32'(m_rx_data), 0);
        rst = 0;

        // idle polling
        for (int i = 0; i < 50 && !arvalid; i++) @(negedge clk);
        chk("first_poll_araddr", araddr, 32'h8);
        cycles(60);
        chk("idle_polls_min", 32'(n_stat >= 4), 1);
        chk("idle_polls_max", 32'(n_stat <= 8), 1);
        chk("idle_err", 32'(err), 0);

        // TX write
        t0 = n_txacc;
        push_wr(32'h0, 32'h5A);
        tx_send(8'h5A, 100);
        wait_wq("tx_5a_written", 100);
        cycles(5);
        chk("tx_5a_one_accept", 32'(n_txacc - t0), 1);

        // tx_busy holds off the write
        status_val = 32'h1;
        t0 = n_txacc;
        s_tx_data = 8'h33; s_tx_valid = 1'b1;
        cycles(40);
        chk("tx_busy_no_accept", 32'(n_txacc - t0), 0);
        push_wr(32'h0, 32'h33);
        status_val = 32'h0;
        tx_send(8'h33, 100);
        wait_wq("tx_33_written", 100);

        // RX drain with stalled consumer
        rx_val = 8'hC3;
        rq.push_back(8'hC3);
        r0 = n_rxrd;
        status_val = 32'h2;
        for (int i = 0; i < 200 && !m_rx_valid; i++) @(negedge clk);
        chk("rx_valid_rise", 32'(m_rx_valid), 1);
        cycles(10);
        chk("rx_held_valid", 32'(m_rx_valid), 1);
        chk("rx_held_data", 32'(m_rx_data), 32'hC3);
        cycles(40);
        chk("rx_single_read", 32'(n_rxrd - r0), 1);
        status_val = 32'h0;
        cycles(10);
        m_rx_ready = 1'b1;
        for (int i = 0; i < 20 && rq.size() != 0; i++) @(negedge clk);
        m_rx_ready = 1'b0;
        chk("rx_consumed", 32'(rq.size()), 0);
        cycles(2);
        chk("rx_valid_clear", 32'(m_rx_valid), 0);

        // baud overwrite while a STATUS read is in flight
        for (int i = 0; i < 100 && !arvalid; i++) @(negedge clk);
        baud_pulse(3'd2);
        for (int i = 0; i < 100 && !rready; i++) @(negedge clk);
        push_wr(32'hC, 32'h5);
        baud_pulse(3'd5);
        wait_wq("baud_written", 100);
        cycles(40);

        // write error is sticky and the byte is not retried
        bresp_cfg = 2'b10;
        t0 = n_txacc;
        push_wr(32'h0, 32'h77);
        tx_send(8'h77, 100);
        wait_wq("err_byte_written", 100);
        cycles(4);
        bresp_cfg = 2'b00;
        chk("err_set", 32'(err), 1);
        cycles(40);
        chk("err_sticky", 32'(err), 1);
        chk("err_one_accept", 32'(n_txacc - t0), 1);

        // reset mid-WR_A
        s_tx_data = 8'h11; s_tx_valid = 1'b1;
        for (int i = 0; i < 100 && !awvalid; i++) @(negedge clk);
        chk("wr_a_reached", 32'(awvalid), 1);
        s_tx_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("midrst_valids", 32'({awvalid, wvalid, arvalid, bready, rready}), 0);
        chk("midrst_err", 32'(err), 0);
        chk("midrst_busy", 32'(busy), 0);
        @(negedge clk);
        rst = 1'b0;
        cycles(30);

        chk("no_rd_wr_overlap", 32'(n_ovl), 0);
        chk("wq_drained", 32'(wq.size()), 0);
        chk("rq_drained", 32'(rq.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/uart_axil_poll_master.md
Name: uart_axil_poll_master

Overview:
- AXI4-Lite initiator that drives the UART register block's slave port: TX_DATA 0x0, RX_DATA 0x4, STATUS 0x8 (bit0 tx_busy, bit1 rx_valid), BAUD_SEL 0xC.
- Converts a local byte-stream TX input and a baud-select request into register writes.
- Polls STATUS and drains received bytes into a byte-stream RX output.
- Sits between a stream client (e.g. a command processor) and the UART register block.

Parameters:
- ADDR_WIDTH, 32, AXI address width.
- DATA_WIDTH, 32, AXI data width.
- BASE_ADDR, 32'h0000_0000, base added to every register offset.
- POLL_DIV, 16, idle cycles between STATUS polls; 0 means poll immediately.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- m_axil_awaddr  out  ADDR_WIDTH  write address
- m_axil_awvalid  out  1  write address valid
- m_axil_awready  in  1  write address ready
- m_axil_wdata  out  DATA_WIDTH  write data
- m_axil_wstrb  out  DATA_WIDTH/8  write strobes, all ones
- m_axil_wvalid  out  1  write data valid
- m_axil_wready  in  1  write data ready
- m_axil_bresp  in  2  write response
- m_axil_bvalid  in  1  write response valid
- m_axil_bready  out  1  write response ready
- m_axil_araddr  out  ADDR_WIDTH  read address
- m_axil_arvalid  out  1  read address valid
- m_axil_arready  in  1  read address ready
- m_axil_rdata  in  DATA_WIDTH  read data
- m_axil_rresp  in  2  read response
- m_axil_rvalid  in  1  read data valid
- m_axil_rready  out  1  read data ready
- s_tx_data  in  8  byte to transmit
- s_tx_valid  in  1  TX byte valid
- s_tx_ready  out  1  TX byte accepted
- m_rx_data  out  8  received byte
- m_rx_valid  out  1  RX byte valid
- m_rx_ready  in  1  RX byte consumed
- baud_sel  in  3  baud code
- baud_sel_wr  in  1  one-cycle request to write baud_sel
- busy  out  1  FSM not in IDLE
- err  out  1  sticky: any non-OKAY bresp/rresp

Behaviour:
- Reset (rst=1 at a clk edge): all valid/ready outputs 0; addresses and wdata 0; m_rx_data 0; err 0; busy 0; state IDLE; poll counter 0; baud pending cleared. Applies mid-transaction too; the slave is reset on the same reset.
- Baud pending:
  - baud_sel_wr captures baud_sel into a pending register and sets the pending flag.
  - A later pulse before service overwrites the value.
  - A pulse in the same cycle the pending write is launched re-arms pending with the new value.
- States:
  - IDLE: if baud pending -> WR_A with BAUD_SEL write. Else increment poll counter; when counter reaches POLL_DIV, clear it -> AR_A (STATUS).
  - AR_A: arvalid=1, araddr latched; hold until arready -> R_D.
  - R_D: rready=1; on rvalid capture rdata/rresp -> DECIDE if STATUS read, else RX_OUT.
  - DECIDE (one cycle), priority order:
    - rresp!=OKAY -> err=1, IDLE.
    - bit1=1 and m_rx_valid=0 -> AR_A (RX_DATA).
    - bit0=0 and s_tx_valid=1 -> s_tx_ready=1 this cycle only, byte captured -> WR_A (TX_DATA, wdata={24'b0,byte}).
    - Otherwise -> IDLE.
  - WR_A: awvalid=1 and wvalid=1 asserted together. Each is dropped independently after its own handshake. When both are done -> WR_B. BAUD_SEL wdata={29'b0,code}.
  - WR_B: bready=1; on bvalid: bresp!=OKAY sets err -> IDLE. A TX byte is considered consumed even on error.
  - RX_OUT: if rresp=OKAY, m_rx_data=rdata[7:0] and m_rx_valid=1; otherwise err=1 and the byte is dropped -> IDLE.
- RX output: m_rx_valid holds until m_rx_valid && m_rx_ready, then clears. At most one RX read is outstanding, and it is issued only while the output is empty.
- Transactions: only one AXI transaction in flight, reads and writes never overlap. AW/W/AR values are stable while valid is high.
- Latency: from IDLE with POLL_DIV=0, arvalid rises 1 cycle after entering IDLE.
- busy = (state != IDLE).

Test Plan:
- POLL_DIV=4, idle slave returning STATUS=0x0, no stimulus -> one STATUS read (araddr=0x8) every 4 idle cycles plus transaction time; no writes; err=0.
- s_tx_valid=1, s_tx_data=0x5A, STATUS=0x0 -> s_tx_ready pulses once; AW addr 0x0, wdata 0x0000005A, wstrb 0xF; bready handshake; next poll follows.
- STATUS=0x1 (tx_busy) with a TX byte pending -> no TX write, s_tx_ready stays 0; once STATUS=0x0 is returned, the write occurs.
- STATUS=0x2, then RX_DATA read (araddr=0x4) returns 0xC3, m_rx_ready=0 for 10 cycles -> m_rx_data=0xC3 held valid; further STATUS=0x2 polls issue no RX read until consumed.
- baud_sel=3'd2 pulse, then baud_sel=3'd5 pulse during a STATUS read -> single write to 0xC with wdata 0x5.
- Write to 0x0 answered with bresp=2'b10 -> err=1 and stays 1; byte not retried. Assert rst mid-WR_A -> next cycle all valids are 0 and err=0.
